// File: rtl/mem_stage_if.sv
// MEM stage handshake/bus bundle: EXE->MEM entry, Data RAM read word,
// MEM->WB result and bypass bus.
interface mem_stage_if;
  logic [79:0] EXE_to_MEM_bus;
  logic        EXE_to_MEM_valid;
  logic        MEM_allow_in;
  logic [31:0] data_ram_r_data;
  logic        WB_allow_in;
  logic        MEM_to_WB_valid;
  logic [69:0] MEM_to_WB_bus;
  logic [39:0] MEM_to_BY_bus;

  modport master (
    output EXE_to_MEM_bus,
    output EXE_to_MEM_valid,
    output data_ram_r_data,
    output WB_allow_in,
    input  MEM_allow_in,
    input  MEM_to_WB_valid,
    input  MEM_to_WB_bus,
    input  MEM_to_BY_bus
  );

  modport slave (
    input  EXE_to_MEM_bus,
    input  EXE_to_MEM_valid,
    input  data_ram_r_data,
    input  WB_allow_in,
    output MEM_allow_in,
    output MEM_to_WB_valid,
    output MEM_to_WB_bus,
    output MEM_to_BY_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: load wait/hold buffer, lane select and extend.
// MEM_LOAD_SIGN_EXT_EN selects sign- instead of zero-extension.
module mem_stage #(
  parameter int LOAD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset,
  mem_stage_if.slave m
);
  localparam logic [1:0] LastCnt = 2'(LOAD_LATENCY - 1);

  logic        r_valid;
  logic [79:0] r_stage;
  logic [31:0] r_hold_data;
  logic        r_held;
  logic [1:0]  r_cnt;

  logic [1:0]  w_vs;
  logic        w_rf_w_en;
  logic        w_is_load;
  logic [1:0]  w_ram_wd;
  logic [3:0]  w_b_en;
  logic [4:0]  w_addr;
  logic [31:0] w_alu;
  logic [31:0] w_pc;
  logic        w_unused;

  assign w_unused  = r_stage[79];
  assign w_vs      = r_stage[78:77];
  assign w_rf_w_en = r_stage[76];
  assign w_is_load = r_stage[75];
  assign w_ram_wd  = r_stage[74:73];
  assign w_b_en    = r_stage[72:69];
  assign w_addr    = r_stage[68:64];
  assign w_alu     = r_stage[63:32];
  assign w_pc      = r_stage[31:0];

  logic w_data_ok;
  logic w_ready_go;
  logic w_allow_in;
  logic w_to_wb_valid;
  logic w_load_stage;
  logic w_wait;
  logic w_last;
  logic w_exit;

  assign w_last        = (r_cnt == LastCnt);
  assign w_data_ok     = r_held | w_last;
  assign w_ready_go    = ~w_is_load | w_data_ok;
  assign w_allow_in    = ~r_valid
                       | (w_ready_go & m.WB_allow_in);
  assign w_to_wb_valid = r_valid & w_ready_go;
  assign w_load_stage  = m.EXE_to_MEM_valid & w_allow_in;
  assign w_wait        = r_valid & w_is_load & ~r_held;
  assign w_exit        = w_to_wb_valid & m.WB_allow_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_stage     <= '0;
      r_hold_data <= '0;
      r_held      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_allow_in) r_valid <= m.EXE_to_MEM_valid;
      if (w_load_stage) begin
        r_stage <= m.EXE_to_MEM_bus;
        r_cnt   <= '0;
        r_held  <= 1'b0;
      end else begin
        if (w_wait && r_cnt < LastCnt)
          r_cnt <= r_cnt + 2'd1;
        // Leaving WB wins over capture so no stale hold survives
        if (w_exit) begin
          r_held <= 1'b0;
        end else if (w_wait && w_last) begin
          r_hold_data <= m.data_ram_r_data;
          r_held      <= 1'b1;
        end
      end
    end
  end

  logic [31:0] w_raw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lane;

  assign w_raw = r_held ? r_hold_data : m.data_ram_r_data;

  always_comb begin
    w_byte = w_raw[7:0];
    w_half = w_raw[15:0];
    case (w_b_en)
      4'b0010: w_byte = w_raw[15:8];
      4'b0100: w_byte = w_raw[23:16];
      4'b1000: w_byte = w_raw[31:24];
      default: w_byte = w_raw[7:0];
    endcase
    if (w_b_en == 4'b1100) w_half = w_raw[31:16];
  end

  always_comb begin
    w_lane = w_raw;
    case (1'b1)
`ifdef MEM_LOAD_SIGN_EXT_EN
      w_ram_wd[1]: w_lane = {{24{w_byte[7]}}, w_byte};
      w_ram_wd[0]: w_lane = {{16{w_half[15]}}, w_half};
`else
      w_ram_wd[1]: w_lane = {24'd0, w_byte};
      w_ram_wd[0]: w_lane = {16'd0, w_half};
`endif
      default:     w_lane = w_raw;
    endcase
  end

  logic [31:0] w_rf_w_value;
  logic        w_by_valid;

  assign w_rf_w_value = w_is_load ? w_lane : w_alu;
  assign w_by_valid   = w_to_wb_valid & (w_vs[0] | w_vs[1]);

  assign m.MEM_allow_in    = w_allow_in;
  assign m.MEM_to_WB_valid = w_to_wb_valid;
  assign m.MEM_to_WB_bus   = {w_rf_w_en, w_addr,
                              w_rf_w_value, w_pc};
  assign m.MEM_to_BY_bus   = {w_addr, w_rf_w_value,
                              w_by_valid, r_valid, w_rf_w_en};
endmodule
